// File: rtl/uart_pkg.sv
// uart_pkg: shared serialiser state encoding, parity modes and parity helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  // Payload is zero-extended to 9 bits, so the padding never disturbs the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_tx_stream_if.sv
// uart_tx_stream_if: valid/ready word stream into the transmitter
interface uart_tx_stream_if #(parameter int DATA_BITS = 8);
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;
  modport master (output in_valid, in_data, input in_ready);
  modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered occupancy count
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign rdata = mem_q[rd_q];
  assign count = count_q;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  // Pointer and count state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset; emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: buffered valid/ready word stream serialised onto a UART line
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 10417,
  parameter int DEPTH        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_stream_if.slave            s,
  output logic                       TxD,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  logic [DATA_BITS-1:0] head;
  logic full, empty, pop, last;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS:0] shift_q, shift_d;
  logic txd_q, txd_d, busy_q, busy_d;
  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s.in_valid && !full),
    .pop   (pop),
    .wdata (s.in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  assign s.in_ready = !full;
  assign last       = baud_q == BW'(CLKS_PER_BIT - 1);
  assign TxD        = txd_q;
  assign busy       = busy_q;
  // Next-state, baud/bit counting and shift register; the line level is derived
  // from the next state so TxD comes straight off a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = last ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d  = '0;
        pop     = !empty;
        state_d = empty ? S_IDLE : S_START;
      end
      S_START: state_d = last ? S_DATA : S_START;
      S_DATA: begin
        if (last) begin
          shift_d = shift_q >> 1;
          bit_d   = (bit_q == 4'(DATA_BITS - 1)) ? 4'd0 : bit_q + 4'd1;
          state_d = (bit_q != 4'(DATA_BITS - 1)) ? S_DATA : (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: state_d = last ? S_STOP : S_PARITY;
      S_STOP: begin
        if (last) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d   = 4'd0;
            pop     = !empty;
            state_d = empty ? S_IDLE : S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) shift_d = {parity_bit(9'(head), 2'(PARITY)), head};
    txd_d  = (state_d == S_START) ? 1'b0 :
             (state_d == S_DATA || state_d == S_PARITY) ? shift_d[0] : 1'b1;
    busy_d = state_d != S_IDLE;
  end
  // Serialiser registers; reset abandons any frame with the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: scoreboard bench with a UART receiver monitor per DUT
module tb_uart_tx_stream;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_stream_if #(.DATA_BITS(8)) ifa ();
  uart_tx_stream_if #(.DATA_BITS(7)) ifb ();
  logic txd_a, busy_a, txd_b, busy_b;
  logic [2:0] cnt_a, cnt_b;
  logic [1:0] txd_v;
  assign txd_v = {txd_b, txd_a};
  uart_tx_stream #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .DEPTH(4)) dut_a (
    .clk(clk), .reset(rst_n), .s(ifa), .TxD(txd_a), .busy(busy_a), .fifo_count(cnt_a));
  uart_tx_stream #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .DEPTH(4)) dut_b (
    .clk(clk), .reset(rst_n), .s(ifb), .TxD(txd_b), .busy(busy_b), .fifo_count(cnt_b));
  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  int run_a = 0, run_b = 0, last_a = 0, last_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Length of the most recent continuous busy interval, in cycles.
  always @(negedge clk) begin
    run_a <= busy_a ? run_a + 1 : 0;
    run_b <= busy_b ? run_b + 1 : 0;
    if (!busy_a && run_a != 0) last_a <= run_a;
    if (!busy_b && run_b != 0) last_b <= run_b;
  end

  task automatic wait_cyc(input int n, inout logic ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  task automatic rx_frame(input int k, input int nbits, input int ns,
                          output logic ab, output logic s0, output logic [8:0] d, output logic [1:0] st);
    ab = 1'b0; d = '0; st = '0;
    wait_cyc(CPB / 2, ab);
    s0 = txd_v[k];
    for (int i = 0; i < nbits; i++) begin
      wait_cyc(CPB, ab);
      d[i] = txd_v[k];
    end
    for (int i = 0; i < ns; i++) begin
      wait_cyc(CPB, ab);
      st[i] = txd_v[k];
    end
    wait_cyc(CPB / 2 - 1, ab);
  endtask

  task automatic monitor(input int k);
    logic ab, s0;
    logic [8:0] d, e;
    logic [1:0] st;
    int ns;
    ns = (k == 0) ? 1 : 2;
    forever begin
      @(negedge clk);
      if (rst_n && txd_v[k] === 1'b0) begin
        rx_frame(k, (k == 0) ? 8 : 8, ns, ab, s0, d, st);
        if (!ab) begin
          if ((k == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame_%0d: got %0h expected none", k, d);
          end else begin
            if (k == 0) e = q_a.pop_front();
            else e = q_b.pop_front();
            chk(k == 0 ? "a_start_bit" : "b_start_bit", 32'(s0), 32'd0);
            chk(k == 0 ? "a_data" : "b_data_parity", 32'(d), 32'(e));
            chk(k == 0 ? "a_stop" : "b_stop", 32'(st), (ns == 2) ? 32'd3 : 32'd1);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic push_a(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    while (!ifa.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("a_push_timeout", 32'(n < 1000), 32'd1);
    @(posedge clk);
    q_a.push_back({1'b0, d});
    #1 ifa.in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [6:0] d, input logic [8:0] exp);
    @(negedge clk);
    ifb.in_valid = 1'b1;
    ifb.in_data  = d;
    chk("b_ready", 32'(ifb.in_ready), 32'd1);
    @(posedge clk);
    q_b.push_back(exp);
    #1 ifb.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_txd_a", 32'(txd_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ready_a", 32'(ifa.in_ready), 32'd1);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_txd_b", 32'(txd_b), 32'd1);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // Single 8N1 word: pop one edge after acceptance, 40-cycle frame.
    push_a(8'hA5);
    chk("single_cnt_after_push", 32'(cnt_a), 32'd1);
    chk("single_txd_before_pop", 32'(txd_a), 32'd1);
    chk("single_busy_before_pop", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    chk("single_txd_start", 32'(txd_a), 32'd0);
    chk("single_busy_start", 32'(busy_a), 32'd1);
    chk("single_cnt_after_pop", 32'(cnt_a), 32'd0);
    wait_idle();
    chk("single_frame_len", 32'(last_a), 32'd40);
    // 7O2: expected payload with hand-computed odd parity in bit 7.
    push_b(7'h55, 9'h0D5);
    wait_idle();
    chk("b_frame_len", 32'(last_b), 32'd44);
    push_b(7'h03, 9'h083);
    push_b(7'h07, 9'h007);
    wait_idle();
    chk("b_two_frame_len", 32'(last_b), 32'd88);
    // Burst into a 4-deep FIFO: fills, stalls, then drains gap-free.
    push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44); push_a(8'h55);
    chk("burst_cnt_full", 32'(cnt_a), 32'd4);
    chk("burst_ready_low", 32'(ifa.in_ready), 32'd0);
    push_a(8'h66);
    wait_idle();
    chk("burst_busy_len", 32'(last_a), 32'd240);
    // Push lands on the same edge as the pop that starts the second frame.
    push_a(8'h81); push_a(8'h42); push_a(8'hC3);
    repeat (39) @(negedge clk);
    chk("simul_cnt_before", 32'(cnt_a), 32'd2);
    chk("simul_txd_stop", 32'(txd_a), 32'd1);
    ifa.in_valid = 1'b1;
    ifa.in_data  = 8'h24;
    @(posedge clk);
    q_a.push_back(9'h024);
    #1 ifa.in_valid = 1'b0;
    chk("simul_cnt_after", 32'(cnt_a), 32'd2);
    chk("simul_txd_next_start", 32'(txd_a), 32'd0);
    wait_idle();
    // Reset during the data bits of frame 2 of 3.
    push_a(8'h0F); push_a(8'hF0); push_a(8'h99);
    repeat (48) @(negedge clk);
    chk("midrst_busy_before", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_cnt", 32'(cnt_a), 32'd0);
    chk("midrst_ready", 32'(ifa.in_ready), 32'd1);
    q_a.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_quiet", 32'(busy_a), 32'd0);
    push_a(8'h3C);
    wait_idle();
    chk("post_rst_frame_len", 32'(last_a), 32'd40);
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
